// File: rtl/vga_text_pkg.sv
// -----------------------------------------------------------------------------
// vga_text_pkg
// Shared constants for the VGA text path: default text-grid geometry, the
// number of character cells, the character address type and a helper that
// sizes modulo counters.
// Optional feature macro used by the text path: VGA_CHAR_SCROLL_EN.
// -----------------------------------------------------------------------------
package vga_text_pkg;

  localparam int unsigned VGA_COLS   = 50;
  localparam int unsigned VGA_ROWS   = 30;
  localparam int unsigned VGA_CELL_W = 8;
  localparam int unsigned VGA_CELL_H = 16;
  localparam int unsigned VGA_ADDR_W = 11;
  localparam int unsigned VGA_CELLS  = VGA_COLS * VGA_ROWS;

  typedef logic [VGA_ADDR_W-1:0] char_addr_t;

  // A modulo-1 counter still needs one bit of storage.
  function automatic int unsigned cnt_width(input int unsigned modulus);
    if (modulus > 32'd1) begin
      return $clog2(modulus);
    end else begin
      return 32'd1;
    end
  endfunction

endpackage

// File: rtl/vga_wrap_counter.sv
// -----------------------------------------------------------------------------
// vga_wrap_counter
// Modulo-MOD counter with synchronous clear and increment.
// Ports:
//   clk    in   clock
//   rst_n  in   synchronous active-low reset
//   clr    in   clear to 0 (wins over inc)
//   inc    in   advance by one, wrapping MOD-1 -> 0
//   cnt    out  current count
//   wrap   out  high in the cycle an increment takes the count from MOD-1 to 0
// -----------------------------------------------------------------------------
module vga_wrap_counter
  import vga_text_pkg::*;
#(
  parameter int unsigned MOD = 8,
  localparam int unsigned W  = cnt_width(MOD)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MOD - 32'd1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count and wrap indication.
  always_comb begin
    cnt_d = cnt_q;
    wrap  = inc & (cnt_q == LAST);
    if (clr) begin
      cnt_d = {W{1'b0}};
    end else if (wrap) begin
      cnt_d = {W{1'b0}};
    end else if (inc) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/vga_char_addr_gen.sv
// -----------------------------------------------------------------------------
// vga_char_addr_gen
// Converts the pixel-enable stream and line/frame markers from the VGA timing
// generator into a character-RAM address plus glyph row/column for the font
// ROM. All outputs are registered: they describe the pixel presented on de in
// the previous cycle.
// Ports:
//   clk          in   pixel clock
//   rst_n        in   synchronous active-low reset
//   frame_start  in   pulse before the first active line of a frame
//   line_end     in   pulse after the last active pixel of each line
//   de           in   active-pixel strobe
//   scroll_row   in   first text row of the frame (VGA_CHAR_SCROLL_EN only)
//   char_addr    out  character RAM address
//   glyph_row    out  line within the glyph
//   glyph_col    out  pixel within the glyph
//   addr_valid   out  outputs belong to an in-grid pixel
//   frame_done   out  pulse after the last glyph line of the last row
// Optional feature: define VGA_CHAR_SCROLL_EN to add scroll_row; the frame then
// starts at that text row and the display rolls circularly.
// -----------------------------------------------------------------------------
module vga_char_addr_gen
  import vga_text_pkg::*;
#(
  parameter int unsigned COLS   = VGA_COLS,
  parameter int unsigned ROWS   = VGA_ROWS,
  parameter int unsigned CELL_W = VGA_CELL_W,
  parameter int unsigned CELL_H = VGA_CELL_H,
  parameter int unsigned ADDR_W = VGA_ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      frame_start,
  input  logic                      line_end,
  input  logic                      de,
`ifdef VGA_CHAR_SCROLL_EN
  input  logic [$clog2(ROWS)-1:0]   scroll_row,
`endif
  output logic [ADDR_W-1:0]         char_addr,
  output logic [$clog2(CELL_H)-1:0] glyph_row,
  output logic [$clog2(CELL_W)-1:0] glyph_col,
  output logic                      addr_valid,
  output logic                      frame_done
);

  localparam int unsigned PX_W = cnt_width(CELL_W);
  localparam int unsigned CC_W = cnt_width(COLS);
  localparam int unsigned GR_W = cnt_width(CELL_H);
  localparam int unsigned CR_W = cnt_width(ROWS);
  localparam int unsigned AW1  = ADDR_W + 32'd1;

  localparam logic [ADDR_W:0] CELLS_L   = AW1'(COLS * ROWS);
  localparam logic [ADDR_W:0] COLS_L    = AW1'(COLS);
  localparam logic [CR_W-1:0] CROW_LAST = CR_W'(ROWS - 32'd1);

  logic [PX_W-1:0] px_s;
  logic [CC_W-1:0] ccol_s;
  logic [GR_W-1:0] grow_s;
  logic [CR_W-1:0] crow_s;
  logic            px_wrap_s, ccol_wrap_s, grow_wrap_s, crow_wrap_s;

  logic            de_take_s;
  logic            le_take_s;
  logic            pos_clr_s;
  logic [ADDR_W-1:0] start_base_s;
  logic [ADDR_W:0]   addr_sum_s;
  logic [ADDR_W:0]   base_sum_s;

  logic              col_over_q, col_over_d;
  logic              row_over_q, row_over_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] char_addr_q, char_addr_d;
  logic [GR_W-1:0]   glyph_row_q, glyph_row_d;
  logic [PX_W-1:0]   glyph_col_q, glyph_col_d;
  logic              addr_valid_q, addr_valid_d;
  logic              frame_done_q, frame_done_d;

  // Event decode: frame_start beats line_end beats de; a pixel is only
  // consumed while both the column and row ranges are still open.
  always_comb begin
    pos_clr_s = frame_start | line_end;
    de_take_s = de & ~frame_start & ~line_end & ~col_over_q & ~row_over_q;
    le_take_s = line_end & ~frame_start & ~row_over_q;
  end

  vga_wrap_counter #(.MOD(CELL_W)) u_px (
    .clk (clk), .rst_n (rst_n), .clr (pos_clr_s), .inc (de_take_s),
    .cnt (px_s), .wrap (px_wrap_s)
  );

  vga_wrap_counter #(.MOD(COLS)) u_ccol (
    .clk (clk), .rst_n (rst_n), .clr (pos_clr_s), .inc (px_wrap_s),
    .cnt (ccol_s), .wrap (ccol_wrap_s)
  );

  vga_wrap_counter #(.MOD(CELL_H)) u_grow (
    .clk (clk), .rst_n (rst_n), .clr (frame_start), .inc (le_take_s),
    .cnt (grow_s), .wrap (grow_wrap_s)
  );

  vga_wrap_counter #(.MOD(ROWS)) u_crow (
    .clk (clk), .rst_n (rst_n), .clr (frame_start), .inc (grow_wrap_s),
    .cnt (crow_s), .wrap (crow_wrap_s)
  );

`ifdef VGA_CHAR_SCROLL_EN
  // Start-of-frame base from the scroll row; out-of-range rows fall back to 0.
  always_comb begin
    if (32'(scroll_row) < ROWS) begin
      start_base_s = ADDR_W'(scroll_row) * ADDR_W'(COLS);
    end else begin
      start_base_s = {ADDR_W{1'b0}};
    end
  end
`else
  assign start_base_s = {ADDR_W{1'b0}};
`endif

  // Address arithmetic, one bit wider so the conditional subtract can wrap.
  always_comb begin
    addr_sum_s = {1'b0, row_base_q} + AW1'(ccol_s);
    if (addr_sum_s >= CELLS_L) begin
      addr_sum_s = addr_sum_s - CELLS_L;
    end else begin
      addr_sum_s = addr_sum_s;
    end
    base_sum_s = {1'b0, row_base_q} + COLS_L;
    if (base_sum_s >= CELLS_L) begin
      base_sum_s = base_sum_s - CELLS_L;
    end else begin
      base_sum_s = base_sum_s;
    end
  end

  // Next-state for flags, row base and the registered outputs.
  always_comb begin
    col_over_d   = col_over_q;
    row_over_d   = row_over_q;
    row_base_d   = row_base_q;
    char_addr_d  = char_addr_q;
    glyph_row_d  = glyph_row_q;
    glyph_col_d  = glyph_col_q;
    addr_valid_d = 1'b0;
    // The last row's counter value is checked directly so the pulse lines up
    // with the line_end that closes the final glyph line.
    frame_done_d = grow_wrap_s & (crow_s == CROW_LAST);

    if (pos_clr_s) begin
      col_over_d = 1'b0;
    end else if (ccol_wrap_s) begin
      col_over_d = 1'b1;
    end else begin
      col_over_d = col_over_q;
    end

    if (frame_start) begin
      row_over_d = 1'b0;
      row_base_d = start_base_s;
    end else if (grow_wrap_s) begin
      row_over_d = row_over_q | crow_wrap_s;
      row_base_d = base_sum_s[ADDR_W-1:0];
    end else begin
      row_over_d = row_over_q;
      row_base_d = row_base_q;
    end

    if (de_take_s) begin
      char_addr_d  = addr_sum_s[ADDR_W-1:0];
      glyph_row_d  = grow_s;
      glyph_col_d  = px_s;
      addr_valid_d = 1'b1;
    end else begin
      addr_valid_d = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_over_q   <= 1'b0;
      row_over_q   <= 1'b0;
      row_base_q   <= {ADDR_W{1'b0}};
      char_addr_q  <= {ADDR_W{1'b0}};
      glyph_row_q  <= {GR_W{1'b0}};
      glyph_col_q  <= {PX_W{1'b0}};
      addr_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_over_q   <= col_over_d;
      row_over_q   <= row_over_d;
      row_base_q   <= row_base_d;
      char_addr_q  <= char_addr_d;
      glyph_row_q  <= glyph_row_d;
      glyph_col_q  <= glyph_col_d;
      addr_valid_q <= addr_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign char_addr  = char_addr_q;
  assign glyph_row  = glyph_row_q;
  assign glyph_col  = glyph_col_q;
  assign addr_valid = addr_valid_q;
  assign frame_done = frame_done_q;

endmodule
